// File: rtl/retire_trace_fifo.sv
// ============================================================================
//  Module   : retire_trace_fifo
//  Brief    : Turns each cycle of CPU retirement activity into a numbered trace
//             record (REG / LOAD / STORE / HALT, optional NOP), buffers records
//             in a FIFO drained over valid/ready, and keeps cycle, instruction
//             and drop counters plus sticky halt and overflow flags.
//             Optional NOP records are enabled by defining TRACE_NOP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retire_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [15:0]      pc,
    input  logic             reg_write,
    input  logic [3:0]       write_reg,
    input  logic [15:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             hlt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_inum,
    output logic [15:0]      out_pc,
    output logic [2:0]       out_type,
    output logic [3:0]       out_reg,
    output logic [15:0]      out_value,
    output logic [15:0]      out_addr,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             halted,
    output logic             overflow
);

    localparam int         c_AW       = $clog2(DEPTH);
    // Record layout: {inum[16], pc[16], type[3], reg[4], value[16], addr[16]}
    localparam int         c_REC_W    = 71;
    localparam logic [2:0] c_TYPE_REG   = 3'd0;
    localparam logic [2:0] c_TYPE_LOAD  = 3'd1;
    localparam logic [2:0] c_TYPE_STORE = 3'd2;
    localparam logic [2:0] c_TYPE_HALT  = 3'd3;
    localparam logic [2:0] c_TYPE_NOP   = 3'd4;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [c_REC_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]      r_wrPtr;
    logic [c_AW:0]      r_rdPtr;
    logic [15:0]        r_inum;
    logic [CNT_W-1:0]   r_cycleCount;
    logic [CNT_W-1:0]   r_instCount;
    logic [CNT_W-1:0]   r_dropCount;
    logic               r_halted;
    logic               r_overflow;

    logic               w_live;
    logic               w_gen;
    logic [2:0]         w_type;
    logic [3:0]         w_reg;
    logic [15:0]        w_value;
    logic [15:0]        w_addr;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_REC_W-1:0] w_head;

    // Capture is live only while enabled and not yet halted.
    assign w_live = en && !r_halted;

    // Classify this cycle's retirement; first matching rule wins.
    always_comb begin
        w_gen   = 1'b0;
        w_type  = c_TYPE_REG;
        w_reg   = 4'd0;
        w_value = 16'd0;
        w_addr  = 16'd0;
        if (w_live) begin
            if (reg_write && mem_read) begin
                w_gen   = 1'b1;
                w_type  = c_TYPE_LOAD;
                w_reg   = write_reg;
                w_value = write_data;
                w_addr  = mem_addr;
            end else if (reg_write) begin
                w_gen   = 1'b1;
                w_type  = c_TYPE_REG;
                w_reg   = write_reg;
                w_value = write_data;
            end else if (hlt) begin
                w_gen   = 1'b1;
                w_type  = c_TYPE_HALT;
            end else if (mem_write) begin
                w_gen   = 1'b1;
                w_type  = c_TYPE_STORE;
                w_value = mem_data;
                w_addr  = mem_addr;
            end else begin
`ifdef TRACE_NOP_EN
                w_gen   = 1'b1;
                w_type  = c_TYPE_NOP;
`else
                w_gen   = 1'b0;
`endif
            end
        end
    end

    // Extra pointer bit distinguishes full from empty when indices match.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                     (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
    assign w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign w_push  = w_gen && (!w_full || w_pop);
    assign w_drop  = w_gen && w_full && !w_pop;

    // Record storage; contents need no reset because outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[c_AW-1:0]] <= {r_inum, pc, w_type, w_reg, w_value, w_addr};
        end
    end

    // Pointers, sequence number, saturating counters and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_inum       <= 16'd0;
            r_cycleCount <= '0;
            r_instCount  <= '0;
            r_dropCount  <= '0;
            r_halted     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_live && (r_cycleCount != c_CNT_MAX)) begin
                r_cycleCount <= r_cycleCount + 1'b1;
            end
            if (w_gen) begin
                r_inum <= r_inum + 16'd1;
                if (r_instCount != c_CNT_MAX) begin
                    r_instCount <= r_instCount + 1'b1;
                end
                if (w_type == c_TYPE_HALT) begin
                    r_halted <= 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropCount != c_CNT_MAX) begin
                    r_dropCount <= r_dropCount + 1'b1;
                end
            end
        end
    end

    // Head record; every field reads zero while the FIFO is empty.
    assign w_head    = w_empty ? '0 : r_mem[r_rdPtr[c_AW-1:0]];
    assign out_valid = !w_empty;
    assign out_inum  = w_head[70:55];
    assign out_pc    = w_head[54:39];
    assign out_type  = w_head[38:36];
    assign out_reg   = w_head[35:32];
    assign out_value = w_head[31:16];
    assign out_addr  = w_head[15:0];

    assign cycle_count = r_cycleCount;
    assign inst_count  = r_instCount;
    assign drop_count  = r_dropCount;
    assign halted      = r_halted;
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_retire_trace_fifo.sv
// ============================================================================
//  Module   : tb_retire_trace_fifo
//  Brief    : Directed and randomized bench for retire_trace_fifo with a
//             queue-based reference model (honours TRACE_NOP_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_retire_trace_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [15:0]      pc;
    logic             reg_write;
    logic [3:0]       write_reg;
    logic [15:0]      write_data;
    logic             mem_read;
    logic             mem_write;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_data;
    logic             hlt;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_inum;
    logic [15:0]      out_pc;
    logic [2:0]       out_type;
    logic [3:0]       out_reg;
    logic [15:0]      out_value;
    logic [15:0]      out_addr;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] drop_count;
    logic             halted;
    logic             overflow;

    always #5 clk = ~clk;

    retire_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .pc(pc),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .hlt(hlt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inum(out_inum), .out_pc(out_pc), .out_type(out_type),
        .out_reg(out_reg), .out_value(out_value), .out_addr(out_addr),
        .cycle_count(cycle_count), .inst_count(inst_count),
        .drop_count(drop_count), .halted(halted), .overflow(overflow)
    );

    typedef struct {
        logic [15:0] inum;
        logic [15:0] pc;
        logic [2:0]  typ;
        logic [3:0]  rg;
        logic [15:0] val;
        logic [15:0] addr;
    } rec_t;

    rec_t        q[$];
    longint      mCyc, mInst, mDrop;
    bit          mHalt, mOvf;
    logic [15:0] mNum;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs as currently driven.
    task automatic model_edge();
        bit   pop;
        bit   gen;
        rec_t r;
        pop = 0;
        gen = 0;
        r   = '{inum: 16'd0, pc: 16'd0, typ: 3'd0, rg: 4'd0, val: 16'd0, addr: 16'd0};
        if (rst) begin
            q.delete();
            mCyc = 0; mInst = 0; mDrop = 0; mHalt = 0; mOvf = 0; mNum = 0;
        end else begin
            pop = (q.size() > 0) && out_ready;
            if (en && !mHalt) begin
                if (mCyc < 64'hFFFF_FFFF) mCyc++;
                r.pc   = pc;
                r.inum = mNum;
                if (reg_write && mem_read) begin
                    gen = 1; r.typ = 1; r.rg = write_reg; r.val = write_data; r.addr = mem_addr;
                end else if (reg_write) begin
                    gen = 1; r.typ = 0; r.rg = write_reg; r.val = write_data;
                end else if (hlt) begin
                    gen = 1; r.typ = 3;
                end else if (mem_write) begin
                    gen = 1; r.typ = 2; r.val = mem_data; r.addr = mem_addr;
                end else begin
`ifdef TRACE_NOP_EN
                    gen = 1; r.typ = 4;
`endif
                end
            end
            if (pop) void'(q.pop_front());
            if (gen) begin
                if (mInst < 64'hFFFF_FFFF) mInst++;
                mNum = mNum + 16'd1;
                if (r.typ == 3) mHalt = 1;
                if (q.size() < DEPTH) q.push_back(r);
                else begin
                    mOvf = 1;
                    if (mDrop < 64'hFFFF_FFFF) mDrop++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("inum",  {48'd0, out_inum},  {48'd0, q[0].inum});
            chk("pc",    {48'd0, out_pc},    {48'd0, q[0].pc});
            chk("type",  {61'd0, out_type},  {61'd0, q[0].typ});
            chk("reg",   {60'd0, out_reg},   {60'd0, q[0].rg});
            chk("value", {48'd0, out_value}, {48'd0, q[0].val});
            chk("addr",  {48'd0, out_addr},  {48'd0, q[0].addr});
        end else begin
            chk("type_empty", {61'd0, out_type}, 64'd0);
        end
        chk("cycle_count", {32'd0, cycle_count}, mCyc);
        chk("inst_count",  {32'd0, inst_count},  mInst);
        chk("drop_count",  {32'd0, drop_count},  mDrop);
        chk("halted",      {63'd0, halted},      {63'd0, mHalt});
        chk("overflow",    {63'd0, overflow},    {63'd0, mOvf});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_in();
        reg_write = 0; write_reg = 0; write_data = 0; mem_read = 0;
        mem_write = 0; mem_addr = 0; mem_data = 0; hlt = 0; pc = 0;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; out_ready = 0;
        idle_in();
        tick();
        rst = 0;
    endtask

    task automatic push_reg(input logic [15:0] p, input logic [3:0] r, input logic [15:0] d);
        idle_in();
        en = 1; pc = p; reg_write = 1; write_reg = r; write_data = d;
        tick();
    endtask

    initial begin
        rst = 1; en = 0; out_ready = 0;
        idle_in();
        // Reset state
        tick();
        tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_inst",  {32'd0, inst_count}, 64'd0);
        rst = 0;

        // Single REG record
        push_reg(16'h0004, 4'd3, 16'h00A5);
        idle_in(); en = 0;
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_type",  {61'd0, out_type},  64'd0);
        chk("t1_inum",  {48'd0, out_inum},  64'd0);
        chk("t1_reg",   {60'd0, out_reg},   64'd3);
        chk("t1_value", {48'd0, out_value}, 64'h00A5);
        chk("t1_pc",    {48'd0, out_pc},    64'h0004);
        chk("t1_inst",  {32'd0, inst_count}, 64'd1);
        tick();  // head holds stable with out_ready=0

        // LOAD then STORE, then drain
        en = 1; pc = 16'h0006; reg_write = 1; mem_read = 1; write_reg = 4'd5;
        mem_addr = 16'h0040; write_data = 16'h1234;
        tick();
        idle_in(); en = 1; pc = 16'h0008; mem_write = 1; mem_data = 16'hBEEF; mem_addr = 16'h0042;
        tick();
        idle_in(); en = 0; out_ready = 1;
        tick();
        chk("t2_load_type", {61'd0, out_type}, 64'd1);
        chk("t2_load_addr", {48'd0, out_addr}, 64'h0040);
        tick();
        chk("t2_store_type",  {61'd0, out_type},  64'd2);
        chk("t2_store_value", {48'd0, out_value}, 64'hBEEF);
        chk("t2_store_reg",   {60'd0, out_reg},   64'd0);
        tick();

        // Overflow: 17 pushes into a 16-deep FIFO, then drain in order
        do_reset();
        for (int i = 0; i < 17; i++) push_reg(16'(i * 2), 4'(i), 16'(16'h100 + i));
        chk("t3_overflow", {63'd0, overflow},     64'd1);
        chk("t3_drop",     {32'd0, drop_count},   64'd1);
        chk("t3_inst",     {32'd0, inst_count},   64'd17);
        idle_in(); en = 0; out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_inum", {48'd0, out_inum}, 64'(i));
            tick();
        end
        chk("t3_empty", {63'd0, out_valid}, 64'd0);

        // Full FIFO with simultaneous pop and push: nothing dropped
        do_reset();
        for (int i = 0; i < 16; i++) push_reg(16'(i), 4'd1, 16'(i));
        out_ready = 1;
        push_reg(16'h0100, 4'd2, 16'h7777);
        chk("t4_overflow", {63'd0, overflow},   64'd0);
        chk("t4_drop",     {32'd0, drop_count}, 64'd0);
        chk("t4_valid",    {63'd0, out_valid},  64'd1);
        idle_in(); en = 0;
        for (int i = 0; i < 17; i++) tick();

        // Halt freezes capture; reset clears everything
        do_reset();
        idle_in(); en = 1; hlt = 1; pc = 16'h0020;
        tick();
        for (int i = 0; i < 3; i++) push_reg(16'(16'h22 + i), 4'd7, 16'h55);
        chk("t5_halted", {63'd0, halted},      64'd1);
        chk("t5_inst",   {32'd0, inst_count},  64'd1);
        chk("t5_cycle",  {32'd0, cycle_count}, 64'd1);
        chk("t5_type",   {61'd0, out_type},    64'd3);
        do_reset();
        chk("t5_rst_halted", {63'd0, halted},      64'd0);
        chk("t5_rst_cycle",  {32'd0, cycle_count}, 64'd0);

        // Idle cycle
        idle_in(); en = 1; pc = 16'h0030;
        tick();
`ifdef TRACE_NOP_EN
        chk("t6_inst",  {32'd0, inst_count}, 64'd1);
        chk("t6_type",  {61'd0, out_type},   64'd4);
`else
        chk("t6_inst",  {32'd0, inst_count}, 64'd0);
        chk("t6_valid", {63'd0, out_valid},  64'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            en         = ($urandom_range(0, 9) != 0);
            pc         = 16'($urandom);
            reg_write  = $urandom_range(0, 1) == 1;
            write_reg  = 4'($urandom);
            write_data = 16'($urandom);
            mem_read   = $urandom_range(0, 2) == 0;
            mem_write  = $urandom_range(0, 2) == 0;
            mem_addr   = 16'($urandom);
            mem_data   = 16'($urandom);
            hlt        = ($urandom_range(0, 149) == 0);
            out_ready  = ($urandom_range(0, 3) == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (i % 400 < 60) out_ready = 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
